// File: rtl/parity_engine_serial.sv
// Serial parity engine: accepts a word on a valid/ready handshake, folds one bit per clock,
// applies the selected parity mode and optionally checks it against a received parity bit.
module parity_engine_serial #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             parity_enable,
    input  logic [1:0]       parity_mode,
    input  logic [LEN_W-1:0] data_len,
    input  logic             check_en,
    input  logic             rx_parity_bit,
    input  logic             Busy,
    input  logic [WIDTH-1:0] DATA,
    input  logic             Data_Valid,
    output logic             in_ready,
    output logic             parity,
    output logic             parity_valid,
    output logic             par_err
);

    typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

    localparam logic [1:0] MODE_EVEN  = 2'b00;
    localparam logic [1:0] MODE_ODD   = 2'b01;
    localparam logic [1:0] MODE_MARK  = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             chk_q, chk_d;
    logic             rxb_q, rxb_d;
    logic             parity_q, parity_d;
    logic             err_q, err_d;
    logic             pv_q, pv_d;
    logic             par_new;

    // Zero or out-of-range lengths fall back to the full word.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len == '0 || len > LEN_W'(WIDTH)) begin
            return LEN_W'(WIDTH);
        end
        return len;
    endfunction

    function automatic logic apply_mode(input logic [1:0] mode, input logic x);
        case (mode)
            MODE_EVEN: return x;
            MODE_ODD:  return ~x;
            MODE_MARK: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

    assign in_ready     = RST && (state_q == IDLE) && parity_enable && !Busy;
    assign parity       = parity_q;
    assign parity_valid = pv_q;
    assign par_err      = err_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            acc_q    <= 1'b0;
            cnt_q    <= '0;
            mode_q   <= 2'b00;
            chk_q    <= 1'b0;
            rxb_q    <= 1'b0;
            parity_q <= 1'b0;
            err_q    <= 1'b0;
            pv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            chk_q    <= chk_d;
            rxb_q    <= rxb_d;
            parity_q <= parity_d;
            err_q    <= err_d;
            pv_q     <= pv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        chk_d    = chk_q;
        rxb_d    = rxb_q;
        parity_d = parity_q;
        err_d    = err_q;
        pv_d     = 1'b0;
        par_new  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Data_Valid && in_ready) begin
                    sh_d    = DATA;
                    mode_d  = parity_mode;
                    cnt_d   = clamp_len(data_len);
                    chk_d   = check_en;
                    rxb_d   = rx_parity_bit;
                    acc_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Losing enable abandons the word without touching the held results.
                if (!parity_enable) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_q ^ sh_q[0];
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        par_new  = apply_mode(mode_q, acc_q ^ sh_q[0]);
                        parity_d = par_new;
                        err_d    = chk_q & (rxb_q != par_new);
                        pv_d     = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
